regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, meaning the number of architectural registers, addressed by 5 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rs1_addr, input, 5, read port 1 address.
REQ-006 SHALL have port rs2_addr, input, 5, read port 2 address.
REQ-007 SHALL have port rs1_data, output, XLEN, read port 1 data, combinational.
REQ-008 SHALL have port rs2_data, output, XLEN, read port 2 data, combinational.
REQ-009 SHALL have port wr_en, input, 1, writeback strobe from the ALU result path.
REQ-010 SHALL have port rd_addr, input, 5, writeback destination.
REQ-011 SHALL have port rd_data, input, XLEN, writeback value, which is the ALU result.
REQ-012 SHALL have port issue_en, input, 1, marks an instruction with destination issue_rd as issued.
REQ-013 SHALL have port issue_rd, input, 5, destination of the issued instruction.
REQ-014 SHALL have port stall, output, 1, high when rs1_addr or rs2_addr names a pending register.

Function
REQ-015 SHALL, on each rising clk with wr_en=1 and rd_addr!=0, store rd_data into register rd_addr.
REQ-016 SHALL ignore writes to x0, and reads of x0 SHALL return 0 at all times.
REQ-017 SHALL drive rs1_data and rs2_data combinationally from the register array with zero-cycle read latency.
REQ-018 SHALL keep a pending bitmap of NREGS bits, where bit 0 is constant 0.
REQ-019 SHALL, on each rising clk, set pending[issue_rd] when issue_en=1 and issue_rd!=0.
REQ-020 SHALL, on each rising clk, clear pending[rd_addr] when wr_en=1.
REQ-021 SHALL give set priority when issue and writeback target the same register in one cycle, so the bit ends at 1.
REQ-022 SHALL drive stall combinationally as (pending[rs1_addr] | pending[rs2_addr]), with addresses of 0 never stalling.
REQ-023 SHALL accept a write to a non-pending register normally and leave pending unchanged.
REQ-024 SHALL let a write and reads to different registers in the same cycle proceed independently.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear all registers to 0 and all pending bits to 0, so that rs1_data=0, rs2_data=0 and stall=0.
REQ-026 SHALL ignore wr_en and issue_en on the first rising edge at which rst_n is low, and SHALL apply no write.
REQ-027 SHALL, when reset is asserted mid-operation, drop all in-flight pending state with no later recovery.

Configuration
REQ-028 SHALL, with macro REGFILE_BYPASS_EN defined, forward rd_data to rs1_data or rs2_data in the same cycle when wr_en=1, rd_addr!=0 and the read address equals rd_addr.
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, mask the pending bit of a register being written that cycle in the stall computation.
REQ-030 SHALL, without REGFILE_BYPASS_EN, have reads return the pre-write array value, so a same-cycle write is visible from the next cycle only, with stall unmasked.

Verification
REQ-031 SHALL cover basic writeback: wr_en=1, rd_addr=1, rd_data=5, one edge, then rs1_addr=1 -> rs1_data=5.
REQ-032 SHALL cover writes to x0: wr_en=1, rd_addr=0, rd_data=0xDEADBEEF, then rs2_addr=0 -> rs2_data=0 and stall=0.
REQ-033 SHALL cover the scoreboard: issue_en=1, issue_rd=3, one edge, then rs1_addr=3 -> stall=1; wr_en=1, rd_addr=3, one edge -> stall=0.
REQ-034 SHALL cover simultaneous issue and writeback: issue_rd=4 and wr rd_addr=4 in the same edge -> pending[4]=1 and rs2_addr=4 gives stall=1.
REQ-035 SHALL cover bypass: x2=7, then wr_en=1, rd_addr=2, rd_data=9, rs1_addr=2 in the same cycle -> rs1_data=9 with REGFILE_BYPASS_EN and 7 without.
REQ-036 SHALL cover reset mid-operation: x5=0x1234 and pending[6]=1, then rst_n low asynchronously between edges -> rs1_addr=5 gives 0 immediately and stall=0 for rs2_addr=6.

Source files
------------

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : Two-read/one-write register file with x0 hardwired to zero and
//            a pending-destination scoreboard that raises stall on hazards.
//            Define REGFILE_BYPASS_EN to forward same-cycle writeback data.
// Revision : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            issue_en,
    input  logic [4:0]      issue_rd,
    output logic            stall
);

    // x0 has no storage; entries start at 1 so it can never be written.
    logic [XLEN-1:0]  r_regs [1:NREGS-1];
    logic [NREGS-1:1] r_pending;

    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_rs1_pend;
    logic             w_rs2_pend;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[gi] <= '0;
                end else if (wr_en && (rd_addr == 5'(gi))) begin
                    r_regs[gi] <= rd_data;
                end
            end

            // Issue is tested first so it wins over a same-cycle writeback.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pending[gi] <= 1'b0;
                end else if (issue_en && (issue_rd == 5'(gi))) begin
                    r_pending[gi] <= 1'b1;
                end else if (wr_en && (rd_addr == 5'(gi))) begin
                    r_pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_rs1_pend = 1'b0;
        w_rs2_pend = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs1_addr == 5'(i)) begin
                w_rs1_data = r_regs[i];
                w_rs1_pend = r_pending[i];
            end
            if (rs2_addr == 5'(i)) begin
                w_rs2_data = r_regs[i];
                w_rs2_pend = r_pending[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // The value being written is the one the reader is waiting for.
        if (wr_en && (rd_addr != 5'd0) && (rs1_addr == rd_addr)) begin
            w_rs1_data = rd_data;
            w_rs1_pend = 1'b0;
        end
        if (wr_en && (rd_addr != 5'd0) && (rs2_addr == rd_addr)) begin
            w_rs2_data = rd_data;
            w_rs2_pend = 1'b0;
        end
`endif
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;
    assign stall    = w_rs1_pend | w_rs2_pend;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Directed self-checking bench for regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wr_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        rd_addr  = 5'd0;
        rd_data  = 32'd0;
        issue_rd = 5'd0;
    endtask

    initial begin
        logic [31:0] exp_byp;
        logic [31:0] exp_stall_wr;

        // Strobes active during reset must be ignored.
        rst_n    = 1'b0;
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        wr_en    = 1'b1;
        rd_addr  = 5'd1;
        rd_data  = 32'hAAAA_5555;
        issue_en = 1'b1;
        issue_rd = 5'd2;
        tick();
        tick();
        check("reset_rs1", rs1_data, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        idle();
        rst_n = 1'b1;
        #1;
        check("post_reset_rs2", rs2_data, 32'd0);
        check("post_reset_stall", {31'd0, stall}, 32'd0);

        // Basic writeback x1 = 5.
        wr_en = 1'b1; rd_addr = 5'd1; rd_data = 32'd5;
        tick();
        idle();
        rs1_addr = 5'd1;
        #1;
        check("wb_x1", rs1_data, 32'd5);

        // Write to x0 is dropped.
        wr_en = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEAD_BEEF;
        tick();
        idle();
        rs2_addr = 5'd0;
        #1;
        check("x0_read", rs2_data, 32'd0);
        check("x0_stall", {31'd0, stall}, 32'd0);

        // Scoreboard: issue x3, then write it back.
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        check("sb_stall_set", {31'd0, stall}, 32'd1);
        check("sb_data_old", rs1_data, 32'd0);
`ifdef REGFILE_BYPASS_EN
        exp_stall_wr = 32'd0;
`else
        exp_stall_wr = 32'd1;
`endif
        wr_en = 1'b1; rd_addr = 5'd3; rd_data = 32'h33;
        #1;
        check("sb_stall_during_wb", {31'd0, stall}, exp_stall_wr);
        tick();
        idle();
        #1;
        check("sb_stall_clear", {31'd0, stall}, 32'd0);
        check("sb_data_new", rs1_data, 32'h33);

        // Simultaneous issue and writeback to x4: set wins.
        issue_en = 1'b1; issue_rd = 5'd4;
        wr_en = 1'b1; rd_addr = 5'd4; rd_data = 32'h44;
        tick();
        idle();
        rs1_addr = 5'd0;
        rs2_addr = 5'd4;
        #1;
        check("simul_stall", {31'd0, stall}, 32'd1);
        check("simul_data", rs2_data, 32'h44);
        wr_en = 1'b1; rd_addr = 5'd4; rd_data = 32'h45;
        tick();
        idle();
        #1;
        check("x4_clear_stall", {31'd0, stall}, 32'd0);

        // Write to a non-pending register leaves the scoreboard alone.
        wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'h77;
        tick();
        idle();
        rs1_addr = 5'd7;
        rs2_addr = 5'd1;
        #1;
        check("nonpend_data", rs1_data, 32'h77);
        check("nonpend_stall", {31'd0, stall}, 32'd0);

        // Same-cycle write and read of x2; independent read of x1.
        wr_en = 1'b1; rd_addr = 5'd2; rd_data = 32'd7;
        tick();
        wr_en = 1'b1; rd_addr = 5'd2; rd_data = 32'd9;
        rs1_addr = 5'd2;
        rs2_addr = 5'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'd9;
`else
        exp_byp = 32'd7;
`endif
        check("bypass_rs1", rs1_data, exp_byp);
        check("indep_rs2", rs2_data, 32'd5);
        tick();
        idle();
        #1;
        check("after_wb_x2", rs1_data, 32'd9);

        // Mid-operation asynchronous reset.
        wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'h1234;
        issue_en = 1'b1; issue_rd = 5'd6;
        tick();
        idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
        #1;
        check("pre_rst_x5", rs1_data, 32'h1234);
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_x5", rs1_data, 32'd0);
        check("async_rst_stall", {31'd0, stall}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        check("no_recover_stall", {31'd0, stall}, 32'd0);
        check("no_recover_x5", rs1_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
